mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    // Width of the instruction-starvation counter; it saturates at all ones.
    localparam int STARVE_W = 3;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [STARVE_W-1:0] starve_t;

    // IDLE: no owner; DACC: data side owns the RAM; IACC: fetch side owns the RAM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data normally wins, but a waiting fetch is forced through after
// STARVE_LIMIT data grants. Every grant returns through IDLE, and a requester
// that drops its request mid-access aborts the grant without a hit.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic  CLK,
    input  logic  RST,
    // instruction side
    input  logic  iREN,
    input  word_t iaddr,
    output logic  ihit,
    output word_t iload,
    // data side
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dhit,
    output word_t dload,
    // RAM side
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic  ram_ready
);

    arb_state_t state_q, state_d;
    starve_t    starve_q, starve_d;

    logic d_req;
    logic starved;

    assign d_req   = dREN | dWEN;
    // A limit above the counter range simply never forces a fetch.
    assign starved = (32'(starve_q) >= STARVE_LIMIT);

    // State and starvation counter; reset takes effect immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state, counter update and all outputs; outputs are gated by RST
    // so they drop in the same cycle reset is raised.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (iREN && starved) begin
                        state_d = IACC;
                    end else if (d_req) begin
                        state_d = DACC;
                    end else if (iREN) begin
                        state_d = IACC;
                    end
                end

                DACC: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    // A simultaneous read and write request is served as a write.
                    ramREN   = dREN & ~dWEN;
                    if (!d_req) begin
                        // Flushed: abort quietly, counter untouched.
                        state_d = IDLE;
                    end else if (ram_ready) begin
                        dhit    = 1'b1;
                        dload   = ramload;
                        state_d = IDLE;
                        if (iREN && (starve_q != '1)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end

                IACC: begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (!iREN) begin
                        state_d = IDLE;
                    end else if (ram_ready) begin
                        ihit     = 1'b1;
                        iload    = ramload;
                        starve_d = '0;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected hits into a
// scoreboard queue, a negedge monitor pops and compares on every hit, and a
// per-cycle invariant check covers exclusivity and idle-zero outputs.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  iREN = 1'b0;
    word_t iaddr = '0;
    logic  ihit;
    word_t iload;
    logic  dREN = 1'b0;
    logic  dWEN = 1'b0;
    word_t daddr = '0;
    word_t dstore = '0;
    logic  dhit;
    word_t dload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload = '0;
    logic  ram_ready = 1'b0;

    typedef struct {
        bit    is_i;
        word_t data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   sb_en = 1'b1;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_hit(input bit is_i, input word_t d);
        exp_t e;
        e.is_i = is_i;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic chk_state(input string name, input arb_state_t s);
        chk(name, 32'(dut.state_q), 32'(s));
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, ".ramREN"}, ramREN, 1'b0);
        chk1({tag, ".ramWEN"}, ramWEN, 1'b0);
        chk({tag, ".ramaddr"}, ramaddr, 32'h0);
        chk({tag, ".ramstore"}, ramstore, 32'h0);
        chk1({tag, ".ihit"}, ihit, 1'b0);
        chk1({tag, ".dhit"}, dhit, 1'b0);
        chk({tag, ".iload"}, iload, 32'h0);
        chk({tag, ".dload"}, dload, 32'h0);
    endtask

    // Scoreboard monitor: every hit must match the oldest expected response.
    always @(negedge CLK) begin
        if (sb_en && (ihit || dhit)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_hit: ihit=%0b dhit=%0b iload=0x%08h dload=0x%08h, none expected",
                         ihit, dhit, iload, dload);
            end else begin
                mon_e = sb_q.pop_front();
                chk1("hit.ihit", ihit, mon_e.is_i);
                chk1("hit.dhit", dhit, !mon_e.is_i);
                chk(mon_e.is_i ? "hit.iload" : "hit.dload",
                    mon_e.is_i ? iload : dload, mon_e.data);
                $display("hit %s data=0x%08h", mon_e.is_i ? "I" : "D", mon_e.is_i ? iload : dload);
            end
        end
    end

    // Invariants checked every cycle, including the random phase.
    always @(negedge CLK) begin
        n_cmp++;
        if ((ihit && dhit) || (ramREN && ramWEN) || ((ihit || dhit) && !ram_ready)
            || (!ihit && iload != 32'h0) || (!dhit && dload != 32'h0)) begin
            n_fail++;
            $display("FAIL invariant: ihit=%0b dhit=%0b ramREN=%0b ramWEN=%0b ram_ready=%0b iload=0x%08h dload=0x%08h",
                     ihit, dhit, ramREN, ramWEN, ram_ready, iload, dload);
        end
    end

    bit    exp_i   [7] = '{0, 0, 0, 0, 1, 0, 0};
    int    exp_cnt [7] = '{1, 2, 3, 4, 0, 1, 2};
    word_t v;

    initial begin
        // Reset held with requests pending: nothing may be granted.
        iREN = 1'b1;
        dWEN = 1'b1;
        ram_ready = 1'b1;
        ramload = 32'h1111_1111;
        cyc();
        chk_quiet("rst");
        chk_state("rst.state", IDLE);
        chk("rst.starve", 32'(dut.starve_q), 32'd0);

        // Release mid-cycle: still IDLE until the next rising edge.
        dWEN = 1'b0;
        ram_ready = 1'b0;
        ramload = '0;
        iaddr = 32'h100;
        RST = 1'b0;
        #1;
        chk_state("rel.state", IDLE);
        chk1("rel.ramREN", ramREN, 1'b0);

        // Instruction read, RAM ready two cycles after grant.
        cyc();
        chk_state("ird.state", IACC);
        chk1("ird.ramREN", ramREN, 1'b1);
        chk1("ird.ramWEN", ramWEN, 1'b0);
        chk("ird.ramaddr", ramaddr, 32'h100);
        chk("ird.ramstore", ramstore, 32'h0);
        chk1("ird.ihit_early", ihit, 1'b0);
        cyc();
        chk1("ird.wait_ihit", ihit, 1'b0);
        cyc();
        ramload = 32'h8C01_0004;
        ram_ready = 1'b1;
        expect_hit(1'b1, 32'h8C01_0004);
        #1;
        chk1("ird.ihit", ihit, 1'b1);
        cyc();
        iREN = 1'b0;
        ram_ready = 1'b0;
        ramload = '0;
        #1;
        chk_state("ird.after", IDLE);
        chk_quiet("ird.after");
        chk("ird.sb_drained", 32'(sb_q.size()), 32'd0);

        // Collision: store wins, then the fetch is served.
        iREN = 1'b1;
        iaddr = 32'h300;
        dWEN = 1'b1;
        daddr = 32'h200;
        dstore = 32'hDEAD_BEEF;
        cyc();
        chk_state("col.state_d", DACC);
        chk1("col.ramWEN", ramWEN, 1'b1);
        chk1("col.ramREN", ramREN, 1'b0);
        chk("col.ramaddr", ramaddr, 32'h200);
        chk("col.ramstore", ramstore, 32'hDEAD_BEEF);
        ramload = 32'h1234_5678;
        ram_ready = 1'b1;
        expect_hit(1'b0, 32'h1234_5678);
        cyc();
        dWEN = 1'b0;
        ram_ready = 1'b0;
        #1;
        chk_state("col.idle", IDLE);
        chk1("col.idle_ramWEN", ramWEN, 1'b0);
        chk("col.starve1", 32'(dut.starve_q), 32'd1);
        cyc();
        chk_state("col.state_i", IACC);
        chk("col.iaddr", ramaddr, 32'h300);
        chk1("col.iREN", ramREN, 1'b1);
        ramload = 32'hCAFE_F00D;
        ram_ready = 1'b1;
        expect_hit(1'b1, 32'hCAFE_F00D);
        cyc();
        iREN = 1'b0;
        ram_ready = 1'b0;
        #1;
        chk_state("col.end", IDLE);
        chk("col.starve0", 32'(dut.starve_q), 32'd0);
        chk("col.sb_drained", 32'(sb_q.size()), 32'd0);

        // Starvation: fetch waits behind data loads, forced after four.
        iREN = 1'b1;
        iaddr = 32'h400;
        dREN = 1'b1;
        daddr = 32'h500;
        ram_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            cyc();
            v = 32'hA000_0000 + 32'(j);
            ramload = v;
            expect_hit(exp_i[j], v);
            #1;
            chk($sformatf("stv.grant%0d_addr", j), ramaddr, exp_i[j] ? 32'h400 : 32'h500);
            chk1($sformatf("stv.grant%0d_ren", j), ramREN, 1'b1);
            cyc();
            if (j == 6) begin
                iREN = 1'b0;
                dREN = 1'b0;
            end
            #1;
            chk_state($sformatf("stv.idle%0d", j), IDLE);
            chk($sformatf("stv.cnt%0d", j), 32'(dut.starve_q), 32'(exp_cnt[j]));
        end
        ram_ready = 1'b0;
        ramload = '0;
        chk("stv.sb_drained", 32'(sb_q.size()), 32'd0);

        // Flush: load granted, request dropped before ram_ready.
        dREN = 1'b1;
        daddr = 32'h600;
        cyc();
        chk_state("fl.state", DACC);
        chk1("fl.ramREN", ramREN, 1'b1);
        chk("fl.ramaddr", ramaddr, 32'h600);
        dREN = 1'b0;
        #1;
        chk1("fl.ramREN_drop", ramREN, 1'b0);
        cyc();
        chk_state("fl.after", IDLE);
        chk_quiet("fl.after");
        chk("fl.starve_kept", 32'(dut.starve_q), 32'd2);

        // Reset raised in the middle of a store.
        dWEN = 1'b1;
        daddr = 32'h700;
        dstore = 32'h55AA_55AA;
        cyc();
        chk1("ra.ramWEN", ramWEN, 1'b1);
        chk("ra.ramaddr", ramaddr, 32'h700);
        ram_ready = 1'b1;
        RST = 1'b1;
        #1;
        chk_quiet("ra.async");
        chk_state("ra.state", IDLE);
        chk("ra.starve", 32'(dut.starve_q), 32'd0);
        cyc();
        chk_state("ra.held", IDLE);
        RST = 1'b0;
        dWEN = 1'b0;
        dREN = 1'b1;
        daddr = 32'h710;
        ram_ready = 1'b0;
        #1;
        chk_state("ra.release", IDLE);
        chk1("ra.release_ramREN", ramREN, 1'b0);
        cyc();
        chk_state("ra.regrant", DACC);
        chk("ra.regrant_addr", ramaddr, 32'h710);
        ramload = 32'h0BAD_F00D;
        ram_ready = 1'b1;
        expect_hit(1'b0, 32'h0BAD_F00D);
        cyc();
        dREN = 1'b0;
        ram_ready = 1'b0;
        #1;
        chk_state("ra.end", IDLE);
        chk("ra.sb_drained", 32'(sb_q.size()), 32'd0);

        // Random traffic: only the per-cycle invariants apply.
        sb_en = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            cyc();
            iREN = 1'($urandom_range(0, 1));
            dREN = 1'($urandom_range(0, 1));
            dWEN = ($urandom_range(0, 3) == 0);
            ram_ready = 1'($urandom_range(0, 1));
            iaddr = $urandom;
            daddr = $urandom;
            dstore = $urandom;
            ramload = $urandom;
        end
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        ram_ready = 1'b0;
        cyc();
        cyc();
        chk_state("rnd.end", IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
